regfile_write_arbiter: RTL and testbench

Sequencer and arbiter for the single write port of the 64 x 32-bit register file. It shares the port between two writeback requesters: A (pipeline/ALU writeback) and B (load/preload path). Each requester uses a valid/ready handshake, and round-robin priority applies when both request. The block also contains a clear sequencer that walks all 64 registers to zero on command. Its outputs drive the register file's regWrite/rd/writeData inputs directly.

---
 rtl/regfile_write_arbiter.sv | 148 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Shares the single write port of the register file between two writeback
// requesters (A: pipeline/ALU, B: load/preload) using round-robin priority.
// It also contains a clear sequencer that writes zero to every register on command.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   a_valid/a_ready       requester A handshake (a_ready is combinational)
//   a_rd, a_data          requester A destination register and data
//   b_valid/b_ready       requester B handshake (b_ready is combinational)
//   b_rd, b_data          requester B destination register and data
//   clr_start             one-cycle request to zero all registers
//   clr_busy              clear sweep in progress
//   clr_done              one-cycle pulse after the last clear write
//   regWrite, rd,         registered write strobe, address and data driven
//   writeData             straight into the register file
module regfile_write_arbiter #(
   parameter int unsigned NUM_REGS = 64,
   parameter int unsigned DATA_W   = 32,
   localparam int unsigned RdW     = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_valid,
   output logic              a_ready,
   input  logic [RdW-1:0]    a_rd,
   input  logic [DATA_W-1:0] a_data,
   input  logic              b_valid,
   output logic              b_ready,
   input  logic [RdW-1:0]    b_rd,
   input  logic [DATA_W-1:0] b_data,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              regWrite,
   output logic [RdW-1:0]    rd,
   output logic [DATA_W-1:0] writeData
);

   localparam logic [0:0] StArb   = 1'b0;
   localparam logic [0:0] StClear = 1'b1;

   localparam logic GrantA = 1'b0;
   localparam logic GrantB = 1'b1;

   localparam logic [RdW-1:0] LastReg = RdW'(NUM_REGS - 1);

   logic [0:0]        state_q, state_d;
   logic [RdW-1:0]    cnt_q, cnt_d;
   logic              last_grant_q, last_grant_d;
   logic              regwrite_q, regwrite_d;
   logic [RdW-1:0]    rd_q, rd_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              clr_done_q, clr_done_d;

   logic arb_en;
   logic a_grant, b_grant;
   logic a_hs, b_hs;

   // A clear request in ARB blocks both requesters for that cycle.
   assign arb_en = (state_q == StArb) && !clr_start;

   // On a conflict the requester that did not win last time is granted.
   assign a_grant = a_valid && (!b_valid || (last_grant_q == GrantB));
   assign b_grant = b_valid && !a_grant;

   assign a_ready = arb_en && a_grant;
   assign b_ready = arb_en && b_grant;

   assign a_hs = a_valid && a_ready;
   assign b_hs = b_valid && b_ready;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      regwrite_d   = 1'b0;
      rd_d         = rd_q;
      wdata_d      = wdata_q;
      clr_done_d   = 1'b0;

      case (state_q)
         StArb: begin
            if (clr_start) begin
               // The first sweep write (register 0) is issued in the next cycle.
               state_d    = StClear;
               cnt_d      = '0;
               regwrite_d = 1'b1;
               rd_d       = '0;
               wdata_d    = '0;
            end else if (a_hs) begin
               regwrite_d   = 1'b1;
               rd_d         = a_rd;
               wdata_d      = a_data;
               last_grant_d = GrantA;
            end else if (b_hs) begin
               regwrite_d   = 1'b1;
               rd_d         = b_rd;
               wdata_d      = b_data;
               last_grant_d = GrantB;
            end
         end
         StClear: begin
            // cnt_q mirrors the address currently presented on rd.
            if (cnt_q == LastReg) begin
               state_d    = StArb;
               cnt_d      = '0;
               clr_done_d = 1'b1;
            end else begin
               cnt_d      = cnt_q + 1'b1;
               regwrite_d = 1'b1;
               rd_d       = cnt_q + 1'b1;
               wdata_d    = '0;
            end
         end
         default: begin
            state_d = StArb;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StArb;
         cnt_q        <= '0;
         last_grant_q <= GrantB;
         regwrite_q   <= 1'b0;
         rd_q         <= '0;
         wdata_q      <= '0;
         clr_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         regwrite_q   <= regwrite_d;
         rd_q         <= rd_d;
         wdata_q      <= wdata_d;
         clr_done_q   <= clr_done_d;
      end
   end

   assign clr_busy  = (state_q == StClear);
   assign clr_done  = clr_done_q;
   assign regWrite  = regwrite_q;
   assign rd        = rd_q;
   assign writeData = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

   logic        clk;
   logic        rst_n;
   logic        a_valid, b_valid;
   logic        a_ready, b_ready;
   logic [5:0]  a_rd, b_rd;
   logic [31:0] a_data, b_data;
   logic        clr_start, clr_busy, clr_done;
   logic        regWrite;
   logic [5:0]  rd;
   logic [31:0] writeData;

   regfile_write_arbiter #(
      .NUM_REGS (64),
      .DATA_W   (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .a_rd      (a_rd),
      .a_data    (a_data),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .b_rd      (b_rd),
      .b_data    (b_data),
      .clr_start (clr_start),
      .clr_busy  (clr_busy),
      .clr_done  (clr_done),
      .regWrite  (regWrite),
      .rd        (rd),
      .writeData (writeData)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      logic [5:0]  rd;
      logic [31:0] data;
   } wr_t;

   wr_t wq[$];   // expected writes, tagged with the cycle they must appear in
   int  dq[$];   // expected clr_done cycles

   int n_checks = 0;
   int n_fail   = 0;
   int wr_seen  = 0;
   int done_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: predicts readies/busy and queues the expected writes.
   initial begin : model
      logic       m_clear;
      int         m_left;
      logic       m_last;  // 1 = B won last
      logic       exp_a, exp_b;
      wr_t        e;
      m_clear = 1'b0;
      m_left  = 0;
      m_last  = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            m_clear = 1'b0;
            m_left  = 0;
            m_last  = 1'b1;
            wq.delete();
            dq.delete();
         end else begin
            exp_a = !m_clear && !clr_start && a_valid && (!b_valid || m_last);
            exp_b = !m_clear && !clr_start && b_valid && (!a_valid || !m_last);
            chk("a_ready", {31'd0, a_ready}, {31'd0, exp_a});
            chk("b_ready", {31'd0, b_ready}, {31'd0, exp_b});
            chk("clr_busy", {31'd0, clr_busy}, {31'd0, m_clear});
            if (!m_clear) begin
               if (clr_start) begin
                  for (int i = 0; i < 64; i++) begin
                     e.cyc  = cyc + 1 + i;
                     e.rd   = 6'(i);
                     e.data = 32'd0;
                     wq.push_back(e);
                  end
                  dq.push_back(cyc + 65);
                  m_clear = 1'b1;
                  m_left  = 64;
               end else if (exp_a) begin
                  e.cyc = cyc + 1; e.rd = a_rd; e.data = a_data;
                  wq.push_back(e);
                  m_last = 1'b0;
               end else if (exp_b) begin
                  e.cyc = cyc + 1; e.rd = b_rd; e.data = b_data;
                  wq.push_back(e);
                  m_last = 1'b1;
               end
            end else begin
               m_left--;
               if (m_left == 0) m_clear = 1'b0;
            end
         end
      end
   end

   // Monitor: compares the register-file port against the queued expectations.
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (regWrite === 1'b1) wr_seen++;
         if (clr_done === 1'b1) done_seen++;
         if (!rst_n) begin
            chk("rst_regWrite", {31'd0, regWrite}, 32'd0);
            chk("rst_rd", {26'd0, rd}, 32'd0);
            chk("rst_writeData", writeData, 32'd0);
            chk("rst_clr_done", {31'd0, clr_done}, 32'd0);
         end else begin
            if (wq.size() > 0 && wq[0].cyc == cyc) begin
               chk("wr_regWrite", {31'd0, regWrite}, 32'd1);
               chk("wr_rd", {26'd0, rd}, {26'd0, wq[0].rd});
               chk("wr_data", writeData, wq[0].data);
               void'(wq.pop_front());
            end else begin
               chk("idle_regWrite", {31'd0, regWrite}, 32'd0);
            end
            if (dq.size() > 0 && dq[0] == cyc) begin
               chk("clr_done", {31'd0, clr_done}, 32'd1);
               void'(dq.pop_front());
            end else begin
               chk("clr_done_idle", {31'd0, clr_done}, 32'd0);
            end
         end
      end
   end

   initial begin : stim
      int snap_wr, snap_done;
      rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; clr_start = 1'b0;
      a_rd = '0; b_rd = '0; a_data = '0; b_data = '0;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // Single A write after reset.
      a_valid = 1'b1; a_rd = 6'd5; a_data = 32'h0000_002A;
      #3 chk("t1_a_ready", {31'd0, a_ready}, 32'd1);
      step();
      a_valid = 1'b0;
      #3 chk("t1_regWrite", {31'd0, regWrite}, 32'd1);
      chk("t1_rd", {26'd0, rd}, 32'd5);
      chk("t1_writeData", writeData, 32'h2A);
      step();
      #3 chk("t1_regWrite_off", {31'd0, regWrite}, 32'd0);
      step();

      // B alone for three cycles, then a conflict that A must win.
      b_valid = 1'b1; b_rd = 6'd7; b_data = 32'h77;
      repeat (3) step();
      a_valid = 1'b1; a_rd = 6'd3; a_data = 32'h33;
      #3 chk("t3_a_wins", {31'd0, a_ready}, 32'd1);
      chk("t3_b_waits", {31'd0, b_ready}, 32'd0);
      step();
      #3 chk("t3_b_next", {31'd0, b_ready}, 32'd1);
      step();
      a_valid = 1'b0; b_valid = 1'b0;
      step();

      // Both continuously valid: writes alternate 1,2,1,2 with no gap.
      a_valid = 1'b1; a_rd = 6'd1; a_data = 32'h11;
      b_valid = 1'b1; b_rd = 6'd2; b_data = 32'h22;
      repeat (4) step();
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (2) step();

      // Clear with A held valid; A is accepted the cycle clr_done pulses.
      a_valid = 1'b1; a_rd = 6'd9; a_data = 32'hDEAD_BEEF; clr_start = 1'b1;
      #3 chk("t4_a_blocked", {31'd0, a_ready}, 32'd0);
      step();
      clr_start = 1'b0;
      repeat (63) begin
         #3 chk("t4_a_hold", {31'd0, a_ready}, 32'd0);
         step();
      end
      #3 chk("t4_a_last", {31'd0, a_ready}, 32'd0);
      step();
      #3 chk("t4_done", {31'd0, clr_done}, 32'd1);
      chk("t4_a_accept", {31'd0, a_ready}, 32'd1);
      step();
      a_valid = 1'b0;
      repeat (2) step();

      // Second clr_start mid-sweep is ignored.
      snap_wr = wr_seen; snap_done = done_seen;
      clr_start = 1'b1;
      step();
      clr_start = 1'b0;
      repeat (29) step();
      clr_start = 1'b1;
      step();
      clr_start = 1'b0;
      repeat (40) step();
      chk("t5_write_count", wr_seen - snap_wr, 32'd64);
      chk("t5_done_count", done_seen - snap_done, 32'd1);

      // Reset in the middle of a sweep.
      snap_done = done_seen;
      clr_start = 1'b1;
      step();
      clr_start = 1'b0;
      repeat (19) step();
      rst_n = 1'b0;
      #1 chk("t6_regWrite", {31'd0, regWrite}, 32'd0);
      chk("t6_clr_busy", {31'd0, clr_busy}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("t6_no_done", done_seen - snap_done, 32'd0);
      a_valid = 1'b1; a_rd = 6'd4; a_data = 32'h44;
      b_valid = 1'b1; b_rd = 6'd6; b_data = 32'h66;
      #3 chk("t6_a_wins", {31'd0, a_ready}, 32'd1);
      chk("t6_b_waits", {31'd0, b_ready}, 32'd0);
      repeat (2) step();
      a_valid = 1'b0; b_valid = 1'b0;
      repeat (3) step();

      chk("end_wq_empty", wq.size(), 32'd0);
      chk("end_dq_empty", dq.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
